// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed frames in, natural-order frames out with valid/ready backpressure.
// Optional early-SOP resynchronisation is enabled by defining FFT_REORDER_SOP_CHECK_EN.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 12,
    parameter int LOG2_N     = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         din_valid,
    output logic                         din_ready,
    input  logic                         din_sop,
    input  logic signed [DATA_WIDTH-1:0] din_real,
    input  logic signed [DATA_WIDTH-1:0] din_imag,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic signed [DATA_WIDTH-1:0] dout_real,
    output logic signed [DATA_WIDTH-1:0] dout_imag,
    output logic                         dout_sop,
    output logic                         dout_eop,
    output logic                         sop_err
);

    localparam int N = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_IDX = {LOG2_N{1'b1}};

    logic signed [DATA_WIDTH-1:0] bank_real [2][N];
    logic signed [DATA_WIDTH-1:0] bank_imag [2][N];

    logic [LOG2_N-1:0] wr_cnt;
    logic [LOG2_N-1:0] wr_cnt_next;
    logic [LOG2_N-1:0] wr_addr;
    logic [LOG2_N-1:0] rd_cnt;
    logic              wr_sel;
    logic              rd_sel;
    logic [1:0]        full;
    logic [1:0]        full_set;
    logic [1:0]        full_clr;
    logic              wr_fire;
    logic              wr_last;
    logic              rd_load;
    logic              rd_last;
    logic              resync;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = v[LOG2_N-1-i];
        end
        return r;
    endfunction

    assign din_ready = !full[wr_sel];
    assign wr_fire   = din_valid && din_ready;
    assign rd_load   = full[rd_sel] && (!dout_valid || dout_ready);
    assign rd_last   = (rd_cnt == LAST_IDX);

`ifdef FFT_REORDER_SOP_CHECK_EN
    assign resync = wr_fire && din_sop && (wr_cnt != '0);
`else
    logic unused_sop;
    assign unused_sop = din_sop;
    assign resync     = 1'b0;
`endif

    // Writer and reader always own different banks, so set and clear never collide.
    always_comb begin
        wr_addr     = bitrev(wr_cnt);
        wr_cnt_next = wr_cnt + LOG2_N'(1);
        wr_last     = (wr_cnt == LAST_IDX);
        if (resync) begin
            wr_addr     = '0;
            wr_cnt_next = LOG2_N'(1);
            wr_last     = 1'b0;
        end
        full_set = '0;
        full_clr = '0;
        if (wr_fire && wr_last) begin
            full_set[wr_sel] = 1'b1;
        end
        if (rd_load && rd_last) begin
            full_clr[rd_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            bank_real[wr_sel][wr_addr] <= din_real;
            bank_imag[wr_sel][wr_addr] <= din_imag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_sel  <= 1'b0;
            full    <= 2'b00;
            sop_err <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt_next;
                if (wr_last) begin
                    wr_sel <= ~wr_sel;
                end
            end
            full    <= (full | full_set) & ~full_clr;
            sop_err <= resync;
        end
    end

    // A taken output with nothing new to load drops valid but keeps the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt     <= '0;
            rd_sel     <= 1'b0;
            dout_valid <= 1'b0;
            dout_real  <= '0;
            dout_imag  <= '0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
        end else if (rd_load) begin
            dout_valid <= 1'b1;
            dout_real  <= bank_real[rd_sel][rd_cnt];
            dout_imag  <= bank_imag[rd_sel][rd_cnt];
            dout_sop   <= (rd_cnt == '0);
            dout_eop   <= rd_last;
            rd_cnt     <= rd_cnt + LOG2_N'(1);
            if (rd_last) begin
                rd_sel <= ~rd_sel;
            end
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: doc/fft_bitrev_reorder.md
# fft_bitrev_reorder

Ping-pong output reorder buffer at the tail of the radix-2 DIF SDF pipeline. It accepts one complex sample per cycle in bit-reversed frame order and returns each frame in natural order. A valid/ready handshake on the output side lets downstream logic apply backpressure. Two N-entry banks alternate so that one frame is written while the previous frame is read.

## Interface
- DATA_WIDTH, 12, signed width of each real/imag component
- LOG2_N, 6, log2 of frame length N; legal range 2..10
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- din_valid  in  1  input sample present
- din_ready  out  1  buffer can accept input this cycle
- din_sop  in  1  marks bit-reversed index 0 of a frame
- din_real  in  DATA_WIDTH  signed real part
- din_imag  in  DATA_WIDTH  signed imaginary part
- dout_valid  out  1  output register holds a sample
- dout_ready  in  1  downstream accepts the output sample
- dout_real  out  DATA_WIDTH  signed real part, natural order
- dout_imag  out  DATA_WIDTH  signed imaginary part, natural order
- dout_sop  out  1  output sample is natural index 0
- dout_eop  out  1  output sample is natural index N-1
- sop_err  out  1  one-cycle pulse: frame resynchronised on an early din_sop

## Operation
- Storage: two banks of N complex entries (bank 0 and bank 1). Banks are not reset. Each bank has a full flag.
- Write side: counter wr_cnt (LOG2_N bits) and bank select wr_sel.
  - din_ready = !full[wr_sel].
  - A sample is accepted when din_valid && din_ready. It is stored at address bitrev(wr_cnt) in bank wr_sel, and wr_cnt increments.
  - When the accepted sample has wr_cnt == N-1: set full[wr_sel], toggle wr_sel, wrap wr_cnt to 0.
- Read side: counter rd_cnt and bank select rd_sel.
  - The output register loads when full[rd_sel] && (!dout_valid || dout_ready). It loads bank[rd_sel][rd_cnt], and rd_cnt increments.
  - dout_sop = (loaded index == 0). dout_eop = (loaded index == N-1).
  - After loading index N-1: clear full[rd_sel], toggle rd_sel, wrap rd_cnt.
- Output register hold/clear:
  - When dout_valid && !dout_ready, the output register holds all output fields.
  - When dout_valid && dout_ready and no new load occurs, dout_valid clears and data holds its last value.
- Simultaneous set and clear: the writer sets the flag of one bank while the reader clears the flag of the other. Both updates take effect in the same cycle. The writer and reader never target the same bank, because the writer only uses a non-full bank and the reader only uses a full one.
- Both banks full: din_ready = 0, and input is stalled until the reader finishes its bank.
- Data passes through unmodified; there is no width change or arithmetic.

## Timing
- Reset (async assert): wr_cnt = rd_cnt = 0, wr_sel = rd_sel = 0, full = 2'b00, dout_valid = 0, dout_real/imag = 0, dout_sop = dout_eop = 0, sop_err = 0. din_ready = 1 after reset.
- Reset asserted mid-frame discards any partially written or partially read frame. Stale bank contents never appear on the output.
- Latency: if the last sample of a frame is accepted at edge k, dout_valid = 1 with natural index 0 after edge k+1.
- Throughput: with dout_ready held at 1, the buffer sustains a continuous stream of one sample per cycle with no input stalls.
- Output registers are outputs of flops. din_ready is a combinational function of flops only.

## Configuration
- Macro: FFT_REORDER_SOP_CHECK_EN.
- Defined: an accepted din_sop with wr_cnt != 0 does the following:
  - discards the partial frame;
  - writes the sample at address 0 and sets wr_cnt = 1;
  - pulses sop_err for one cycle.
- Defined: an accepted din_sop with wr_cnt == 0 has no special effect.
- Not defined: din_sop is ignored, sop_err is tied to 0, and framing relies solely on wr_cnt.

## Test plan
All scenarios use LOG2_N = 3 (N = 8). The bit-reversed order is 0,4,2,6,1,5,3,7.
1. Single frame: drive din_real = 0,4,2,6,1,5,3,7 with imag = -real and dout_ready = 1. Required: dout_real = 0..7 and dout_imag = 0,-1..-7 on consecutive cycles; sop on the first output, eop on the last; first dout_valid one cycle after the last input edge.
2. Back-to-back: send 4 frames continuously with dout_ready = 1. Required: din_ready stays 1 and output is continuous after the first frame latency; frame f, index i carries value 8f+i.
3. Backpressure: hold dout_ready = 0 while sending 3 frames. Required: din_ready drops after 16 accepted samples and dout holds index 0 of frame 0. Releasing dout_ready yields frames 0 and 1 in order, then frame 2 is accepted.
4. Random dout_ready and din_valid (50%) over 20 frames. Required: every sample appears exactly once, in order, with no loss or duplication.
5. Assert rst_n low after 5 inputs of a frame and after 3 outputs of a frame. Required: all outputs go to reset values immediately, and the next full frame reorders correctly.
6. With FFT_REORDER_SOP_CHECK_EN defined: assert din_sop at wr_cnt = 5. Required: sop_err = 1 for one cycle, and the frame starting at that sample is output correctly. Without the macro, sop_err stays 0.
